// File: rtl/trdb_pkg.sv
// rtl/trdb_pkg.sv - shared types and constants for the trace debugger register path
// Contents: register offsets, APB bridge FSM state type, bridge timeout default.
package trdb_pkg;

  localparam logic [11:0] REG_TRDB_CTRL   = 12'h000;
  localparam logic [11:0] REG_TRDB_STATUS = 12'h004;
  localparam logic [11:0] REG_TRDB_FILTER = 12'h008;
  localparam logic [11:0] REG_TRDB_DUMP   = 12'h00C;

  localparam int unsigned TRDB_APB_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } trdb_apb_state_e;

endpackage

// File: rtl/trdb_apb_bridge.sv
// rtl/trdb_apb_bridge.sv - APB3 completer driving the trace debugger register request interface
// Ports:
//   clk_i, rst_ni                                   clock, async active-low reset
//   paddr_i, pwdata_i, pwrite_i, psel_i, penable_i  APB request
//   prdata_o, pready_o, pslverr_o                   APB response (all decoded from registers)
//   per_valid_o, per_we_o, per_addr_o, per_wdata_o  register file request
//   per_rdata_i, per_ready_i                        register file response
module trdb_apb_bridge
  import trdb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned DECODE_MSB     = 7,
  parameter int unsigned TIMEOUT_CYCLES = TRDB_APB_TIMEOUT_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      per_valid_o,
  output logic                      per_we_o,
  output logic [APB_ADDR_WIDTH-1:0] per_addr_o,
  output logic [31:0]               per_wdata_o,
  input  logic [31:0]               per_rdata_i,
  input  logic                      per_ready_i
);

  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  // Address bits above DECODE_MSB; a shift of the full width yields an empty mask.
  localparam logic [APB_ADDR_WIDTH-1:0] HI_MASK = {APB_ADDR_WIDTH{1'b1}} << (DECODE_MSB + 1);

  trdb_apb_state_e           state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      we_q, we_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      addr_ok;

  assign addr_ok = (paddr_i[1:0] == 2'b00) && ((paddr_i & HI_MASK) == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (psel_i && penable_i) begin
          addr_d  = paddr_i;
          wdata_d = pwdata_i;
          we_d    = pwrite_i;
          state_d = addr_ok ? REQ : ERR;
        end
      end
      REQ: begin
        if (per_ready_i) begin
          rdata_d = we_q ? 32'h0 : per_rdata_i;
          state_d = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d = ERR;
        end else begin
          // Counter only survives while staying in REQ; any exit leaves cnt_d at 0.
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output decodes registered state, so neither side sees a combinational path.
  assign per_valid_o = (state_q == REQ);
  assign per_we_o    = (state_q == REQ) && we_q;
  assign per_addr_o  = addr_q;
  assign per_wdata_o = wdata_q;
  assign pready_o    = (state_q == DONE) || (state_q == ERR);
  assign pslverr_o   = (state_q == ERR);
  assign prdata_o    = (state_q == DONE) ? rdata_q : 32'h0;

`ifndef SYNTHESIS
  // The master must hold the transfer until pready; the request completes regardless.
  a_psel_held_in_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == REQ) |-> psel_i);
`endif

endmodule

// File: tb/tb_trdb_apb_bridge.sv
// tb/tb_trdb_apb_bridge.sv - self-checking bench for trdb_apb_bridge
module tb_trdb_apb_bridge;
  import trdb_pkg::*;

  localparam int T = TRDB_APB_TIMEOUT_DEFAULT;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [11:0] paddr_i = '0;
  logic [31:0] pwdata_i = '0;
  logic        pwrite_i = 1'b0;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  logic        per_valid_o;
  logic        per_we_o;
  logic [11:0] per_addr_o;
  logic [31:0] per_wdata_o;
  logic [31:0] per_rdata_i = '0;
  logic        per_ready_i = 1'b0;

  trdb_apb_bridge #(
    .APB_ADDR_WIDTH(12),
    .DECODE_MSB    (7),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .paddr_i    (paddr_i),
    .pwdata_i   (pwdata_i),
    .pwrite_i   (pwrite_i),
    .psel_i     (psel_i),
    .penable_i  (penable_i),
    .prdata_o   (prdata_o),
    .pready_o   (pready_o),
    .pslverr_o  (pslverr_o),
    .per_valid_o(per_valid_o),
    .per_we_o   (per_we_o),
    .per_addr_o (per_addr_o),
    .per_wdata_o(per_wdata_o),
    .per_rdata_i(per_rdata_i),
    .per_ready_i(per_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] rsp_mem [64];
  logic [31:0] exp_mem [64];

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        w;
    int          dly;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_v;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [95:0] outs();
    return {16'h0, prdata_o, pready_o, pslverr_o, per_valid_o, per_we_o, per_addr_o, per_wdata_o};
  endfunction

  // Expected completion from the transfer rules: latency counted from the access-phase cycle.
  task automatic model(input logic [11:0] a, input int dly,
                       output int lat, output logic err, output int vcnt);
    if (a[1:0] != 2'b00 || a[11:8] != 4'h0) begin
      lat = 1; err = 1'b1; vcnt = 0;
    end else if (dly < T) begin
      lat = 2 + dly; err = 1'b0; vcnt = dly + 1;
    end else begin
      lat = T + 1; err = 1'b1; vcnt = T;
    end
  endtask

  // One APB transfer with a register-file responder that answers after dly wait cycles.
  task automatic xfer(input logic [11:0] a, input logic [31:0] d, input logic w, input int dly,
                      output int lat, output logic err, output logic [31:0] rd,
                      output int vcnt, output logic bad);
    lat = -1; err = 1'b0; rd = '0; vcnt = 0; bad = 1'b0;
    paddr_i = a; pwdata_i = d; pwrite_i = w; psel_i = 1'b1; penable_i = 1'b0; per_ready_i = 1'b0;
    tick();
    if (pready_o || per_valid_o) bad = 1'b1;
    penable_i = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      tick();
      per_ready_i = 1'b0;
      if (per_valid_o) begin
        vcnt++;
        if (per_addr_o !== a || per_wdata_o !== d || per_we_o !== w) bad = 1'b1;
        if (vcnt == dly + 1) begin
          per_ready_i = 1'b1;
          per_rdata_i = rsp_mem[per_addr_o[7:2]];
          if (per_we_o) rsp_mem[per_addr_o[7:2]] = per_wdata_o;
        end else begin
          per_rdata_i = $urandom();
        end
      end
      if (pready_o) begin
        lat = n; err = pslverr_o; rd = prdata_o;
        break;
      end else if (prdata_o !== 32'h0 || pslverr_o) begin
        bad = 1'b1;
      end
    end
    psel_i = 1'b0; penable_i = 1'b0; per_ready_i = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [11:0] a, input logic [31:0] d,
                           input logic w, input int dly, input int exp_lat, input logic exp_err,
                           input logic [31:0] exp_rd, input int exp_v);
    int lat, vcnt;
    logic err, bad;
    logic [31:0] rd;
    xfer(a, d, w, dly, lat, err, rd, vcnt, bad);
    chk({tag, " latency"}, 96'(lat), 96'(exp_lat));
    chk({tag, " pslverr"}, 96'(err), 96'(exp_err));
    chk({tag, " prdata"}, 96'(rd), 96'(exp_rd));
    chk({tag, " valid cycles"}, 96'(vcnt), 96'(exp_v));
    chk({tag, " request stable"}, 96'(bad), 96'(0));
  endtask

  initial begin
    int lat, vcnt;
    logic err, w, bad;
    logic [11:0] a;
    logic [31:0] d;
    int dly, r;

    for (int i = 0; i < 64; i++) begin
      rsp_mem[i] = '0;
      exp_mem[i] = '0;
    end
    rsp_mem[1] = 32'h1F;
    exp_mem[1] = 32'h1F;

    tbl[0] = '{REG_TRDB_CTRL,   32'h0000_0003, 1'b1, 0,  2,     1'b0, 32'h0,  1};
    tbl[1] = '{REG_TRDB_STATUS, 32'h0,         1'b0, 0,  2,     1'b0, 32'h1F, 1};
    tbl[2] = '{12'h006,         32'h0,         1'b0, 0,  1,     1'b1, 32'h0,  0};
    tbl[3] = '{12'h100,         32'h0,         1'b0, 0,  1,     1'b1, 32'h0,  0};
    tbl[4] = '{12'h014,         32'h1234_5678, 1'b1, 99, T + 1, 1'b1, 32'h0,  T};
    tbl[5] = '{REG_TRDB_DUMP,   32'h0000_0055, 1'b1, 3,  5,     1'b0, 32'h0,  4};
    tbl[6] = '{REG_TRDB_FILTER, 32'h0000_00AA, 1'b1, 0,  2,     1'b0, 32'h0,  1};
    tbl[7] = '{REG_TRDB_FILTER, 32'h0,         1'b0, 1,  3,     1'b0, 32'hAA, 2};

    repeat (3) tick();
    chk("reset outputs", outs(), 96'h0);
    rst_ni = 1'b1;
    tick();
    chk("outputs after reset release", outs(), 96'h0);

    for (int i = 0; i < 8; i++) begin
      run_check($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wdata, tbl[i].w, tbl[i].dly,
                tbl[i].exp_lat, tbl[i].exp_err, tbl[i].exp_rd, tbl[i].exp_v);
      if (tbl[i].w && !tbl[i].exp_err) exp_mem[tbl[i].addr[7:2]] = tbl[i].wdata;
    end

    // Reset in the middle of a write that the register file never acknowledges.
    paddr_i = 12'h010; pwdata_i = 32'hDEAD_BEEF; pwrite_i = 1'b1; psel_i = 1'b1; penable_i = 1'b0;
    tick();
    penable_i = 1'b1;
    tick();
    tick();
    chk("request pending before reset", 96'(per_valid_o), 96'(1));
    #2 rst_ni = 1'b0;
    #1 chk("outputs cleared by async reset", outs(), 96'h0);
    psel_i = 1'b0; penable_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (per_valid_o || pready_o) bad = 1'b1;
    end
    chk("no replay after reset", 96'(bad), 96'(0));
    run_check("post-reset read", 12'h010, 32'h0, 1'b0, 0, 2, 1'b0, exp_mem[4], 1);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = {4'h0, 6'($urandom_range(0, 63)), 2'b00};
      else if (r == 7) a = {4'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else             a = {4'($urandom_range(1, 15)), 8'($urandom_range(0, 255))};
      w = 1'($urandom_range(0, 1));
      d = $urandom();
      dly = (i % 8 == 5) ? $urandom_range(T, T + 4) : $urandom_range(0, 6);
      model(a, dly, lat, err, vcnt);
      run_check($sformatf("rand%0d", i), a, d, w, dly, lat, err,
                (w || err) ? 32'h0 : exp_mem[a[7:2]], vcnt);
      if (w && !err) exp_mem[a[7:2]] = d;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
